// File: rtl/hit_detection_matrix.sv
// Programmable pairwise collision detector: per-rule first-hit pulse and coordinate capture,
// per-frame summary, and a show-ahead event FIFO with a saturating drop counter.
module hit_detection_matrix #(
  parameter int N_OBJ      = 9,
  parameter int N_RULES    = 7,
  parameter logic [N_RULES*N_OBJ-1:0] RULE_MASK_A = '0,
  parameter logic [N_RULES*N_OBJ-1:0] RULE_MASK_B = '0,
  parameter int COORD_W    = 11,
  parameter int FIFO_DEPTH = 4,
  localparam int RW = (N_RULES > 1) ? $clog2(N_RULES) : 1
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic [N_OBJ-1:0]   hit_request,
  input  logic [COORD_W-1:0] pixelX,
  input  logic [COORD_W-1:0] pixelY,
  output logic [N_RULES-1:0] collision,
  output logic [N_RULES-1:0] HitPulse,
  output logic [N_RULES-1:0] frame_summary,
  output logic               evt_valid,
  input  logic               evt_ready,
  output logic [RW-1:0]      evt_rule,
  output logic [COORD_W-1:0] evt_x,
  output logic [COORD_W-1:0] evt_y,
  output logic [7:0]         drop_count
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [N_RULES-1:0] flags_q, flags_d;
  logic [N_RULES-1:0] pending_q, pending_d;
  logic [N_RULES-1:0] hit_pulse_q;
  logic [N_RULES-1:0] summary_q, summary_d;
  logic [7:0]         drop_q, drop_d;
  logic [COORD_W-1:0] cap_x_q [N_RULES];
  logic [COORD_W-1:0] cap_y_q [N_RULES];

  logic [RW-1:0]      mem_rule_q [FIFO_DEPTH];
  logic [COORD_W-1:0] mem_x_q    [FIFO_DEPTH];
  logic [COORD_W-1:0] mem_y_q    [FIFO_DEPTH];
  logic [AW:0]        wr_ptr_q, rd_ptr_q;

  logic [N_RULES-1:0] collision_c, new_hit, push_oh, pend_after, discard;
  logic [RW-1:0]      push_idx;
  logic [COORD_W-1:0] push_x, push_y;
  logic               fifo_empty, fifo_full, pop, push_en;
  logic [8:0]         drop_sum;

  always_comb begin
    collision_c = '0;
    for (int k = 0; k < N_RULES; k++) begin
      collision_c[k] = (|(hit_request & RULE_MASK_A[k*N_OBJ +: N_OBJ])) &
                       (|(hit_request & RULE_MASK_B[k*N_OBJ +: N_OBJ]));
    end
  end
  assign collision = collision_c;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop        = !fifo_empty && evt_ready;

  // Descending scan leaves the lowest-index pending rule selected.
  always_comb begin
    push_oh  = '0;
    push_idx = '0;
    push_x   = '0;
    push_y   = '0;
    for (int k = N_RULES - 1; k >= 0; k--) begin
      if (pending_q[k]) begin
        push_oh    = '0;
        push_oh[k] = 1'b1;
        push_idx   = RW'(k);
        push_x     = cap_x_q[k];
        push_y     = cap_y_q[k];
      end
    end
  end

  assign push_en = (|pending_q) && (!fifo_full || pop);

  // The push of the current cycle still goes out at a frame boundary; only what remains is dropped.
  always_comb begin
    new_hit    = collision_c & ~(startOfFrame ? '0 : flags_q);
    flags_d    = (startOfFrame ? '0 : flags_q) | collision_c;
    summary_d  = startOfFrame ? flags_q : summary_q;
    pend_after = pending_q & ~(push_en ? push_oh : '0);
    discard    = startOfFrame ? pend_after : '0;
    pending_d  = (startOfFrame ? '0 : pend_after) | new_hit;
    drop_sum   = {1'b0, drop_q};
    for (int k = 0; k < N_RULES; k++) begin
      drop_sum = drop_sum + 9'(discard[k]);
    end
    drop_d = (drop_sum > 9'd255) ? 8'hFF : drop_sum[7:0];
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      flags_q     <= '0;
      pending_q   <= '0;
      hit_pulse_q <= '0;
      summary_q   <= '0;
      drop_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      for (int k = 0; k < N_RULES; k++) begin
        cap_x_q[k] <= '0;
        cap_y_q[k] <= '0;
      end
    end else begin
      flags_q     <= flags_d;
      pending_q   <= pending_d;
      hit_pulse_q <= new_hit;
      summary_q   <= summary_d;
      drop_q      <= drop_d;
      for (int k = 0; k < N_RULES; k++) begin
        if (new_hit[k]) begin
          cap_x_q[k] <= pixelX;
          cap_y_q[k] <= pixelY;
        end
      end
      if (push_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage needs no reset: the head is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (resetN && push_en) begin
      mem_rule_q[wr_ptr_q[AW-1:0]] <= push_idx;
      mem_x_q[wr_ptr_q[AW-1:0]]    <= push_x;
      mem_y_q[wr_ptr_q[AW-1:0]]    <= push_y;
    end
  end

  assign HitPulse      = hit_pulse_q;
  assign frame_summary = summary_q;
  assign drop_count    = drop_q;
  assign evt_valid     = !fifo_empty;
  assign evt_rule      = evt_valid ? mem_rule_q[rd_ptr_q[AW-1:0]] : '0;
  assign evt_x         = evt_valid ? mem_x_q[rd_ptr_q[AW-1:0]]    : '0;
  assign evt_y         = evt_valid ? mem_y_q[rd_ptr_q[AW-1:0]]    : '0;

endmodule

// File: tb/tb_hit_detection_matrix.sv
// Bench for hit_detection_matrix: table vectors, directed corner sequences and a randomized run
// compared every cycle against a queue-based frame/event model.
module tb_hit_detection_matrix;

  localparam int NO = 9;
  localparam int NR = 7;
  localparam int CW = 11;
  localparam int FD = 4;

  // Rule k: group A = object k; group B = object 7 for even k, object 8 for odd k.
  function automatic logic [NR*NO-1:0] mk_mask(input bit is_b);
    logic [NR*NO-1:0] m;
    m = '0;
    for (int k = 0; k < NR; k++) begin
      if (!is_b) m[k*NO + k] = 1'b1;
      else       m[k*NO + ((k % 2 == 0) ? 7 : 8)] = 1'b1;
    end
    return m;
  endfunction

  localparam logic [NR*NO-1:0] MA = mk_mask(1'b0);
  localparam logic [NR*NO-1:0] MB = mk_mask(1'b1);

  logic          clk = 0;
  logic          resetN = 0;
  logic          startOfFrame = 0;
  logic [NO-1:0] hit_request = '0;
  logic [CW-1:0] pixelX = '0, pixelY = '0;
  logic          evt_ready = 0;
  logic [NR-1:0] collision, HitPulse, frame_summary;
  logic          evt_valid;
  logic [2:0]    evt_rule;
  logic [CW-1:0] evt_x, evt_y;
  logic [7:0]    drop_count;

  hit_detection_matrix #(
    .N_OBJ(NO), .N_RULES(NR), .RULE_MASK_A(MA), .RULE_MASK_B(MB),
    .COORD_W(CW), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .hit_request(hit_request),
    .pixelX(pixelX), .pixelY(pixelY), .collision(collision), .HitPulse(HitPulse),
    .frame_summary(frame_summary), .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_rule(evt_rule), .evt_x(evt_x), .evt_y(evt_y), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: frame flags, pending events, captured coordinates and an event queue.
  typedef struct { int r; int x; int y; } evt_t;
  evt_t      m_q[$];
  bit [NR-1:0] m_flags, m_pend, m_pulse, m_sum;
  int        m_drop;
  int        m_cx[NR], m_cy[NR];

  function automatic bit [NR-1:0] model_col();
    bit [NR-1:0] c;
    for (int k = 0; k < NR; k++) begin
      bit a, b;
      a = 0; b = 0;
      for (int i = 0; i < NO; i++) begin
        if (hit_request[i] && MA[k*NO + i]) a = 1;
        if (hit_request[i] && MB[k*NO + i]) b = 1;
      end
      c[k] = a && b;
    end
    return c;
  endfunction

  task automatic model_step();
    bit [NR-1:0] c;
    bit pop;
    int pk;
    c = model_col();
    if (!resetN) begin
      m_q.delete();
      m_flags = '0; m_pend = '0; m_pulse = '0; m_sum = '0; m_drop = 0;
      for (int k = 0; k < NR; k++) begin m_cx[k] = 0; m_cy[k] = 0; end
      return;
    end
    pop = (m_q.size() > 0) && evt_ready;
    pk = -1;
    for (int k = NR - 1; k >= 0; k--) if (m_pend[k]) pk = k;
    if (pop) void'(m_q.pop_front());
    if (pk >= 0 && (m_q.size() < FD)) begin
      m_q.push_back('{pk, m_cx[pk], m_cy[pk]});
      m_pend[pk] = 0;
    end
    if (startOfFrame) begin
      m_sum  = m_flags;
      m_drop = m_drop + $countones(m_pend);
      if (m_drop > 255) m_drop = 255;
      m_flags = '0;
      m_pend  = '0;
    end
    m_pulse = '0;
    for (int k = 0; k < NR; k++) begin
      if (c[k] && !m_flags[k]) begin
        m_flags[k] = 1; m_pend[k] = 1; m_pulse[k] = 1;
        m_cx[k] = int'(pixelX); m_cy[k] = int'(pixelY);
      end
    end
  endtask

  task automatic check_all();
    chk("HitPulse", 32'(HitPulse), 32'(m_pulse));
    chk("frame_summary", 32'(frame_summary), 32'(m_sum));
    chk("drop_count", 32'(drop_count), 32'(m_drop));
    chk("evt_valid", 32'(evt_valid), 32'(m_q.size() > 0));
    if (m_q.size() > 0) begin
      chk("evt_rule", 32'(evt_rule), 32'(m_q[0].r));
      chk("evt_x", 32'(evt_x), 32'(m_q[0].x));
      chk("evt_y", 32'(evt_y), 32'(m_q[0].y));
    end
  endtask

  task automatic tick();
    #1;
    chk("collision", 32'(collision), 32'(model_col()));
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  typedef struct { logic [NO-1:0] hit; logic [NR-1:0] col; } vec_t;
  vec_t tbl[12];

  initial begin
    int cnt, last_rule;

    tbl[0]  = '{9'h081, 7'b0000001};
    tbl[1]  = '{9'h101, 7'b0000000};
    tbl[2]  = '{9'h102, 7'b0000010};
    tbl[3]  = '{9'h1FF, 7'b1111111};
    tbl[4]  = '{9'h07F, 7'b0000000};
    tbl[5]  = '{9'h0C0, 7'b1000000};
    tbl[6]  = '{9'h140, 7'b0000000};
    tbl[7]  = '{9'h180, 7'b0000000};
    tbl[8]  = '{9'h1AA, 7'b0101010};
    tbl[9]  = '{9'h0D5, 7'b1010101};
    tbl[10] = '{9'h1C9, 7'b1001001};
    tbl[11] = '{9'h000, 7'b0000000};

    // Reset with every object drawing.
    resetN = 0; hit_request = '1;
    tick(); tick();
    chk("rst_HitPulse", 32'(HitPulse), 32'd0);
    chk("rst_evt_valid", 32'(evt_valid), 32'd0);
    chk("rst_drop", 32'(drop_count), 32'd0);
    chk("rst_evt_x", 32'(evt_x), 32'd0);
    resetN = 1; hit_request = '0;
    startOfFrame = 1; tick(); startOfFrame = 0;

    // Single rule, three-pixel overlap at (100,50).
    hit_request = 9'h081; pixelX = 100; pixelY = 50;
    #1 chk("t2_col0", 32'(collision[0]), 32'd1);
    tick();
    chk("t2_pulse", 32'(HitPulse), 32'd1);
    chk("t2_valid_early", 32'(evt_valid), 32'd0);
    #1 chk("t2_col1", 32'(collision[0]), 32'd1);
    tick();
    chk("t2_pulse_once", 32'(HitPulse), 32'd0);
    chk("t2_valid", 32'(evt_valid), 32'd1);
    chk("t2_rule", 32'(evt_rule), 32'd0);
    chk("t2_x", 32'(evt_x), 32'd100);
    chk("t2_y", 32'(evt_y), 32'd50);
    #1 chk("t2_col2", 32'(collision[0]), 32'd1);
    tick();
    chk("t2_pulse_once2", 32'(HitPulse), 32'd0);
    hit_request = '0;

    // Three rules in one cycle drained back to back.
    evt_ready = 1; startOfFrame = 1; tick(); startOfFrame = 0;
    hit_request = 9'h1C9; pixelX = 20; pixelY = 30;
    tick();
    chk("t3_pulse", 32'(HitPulse), 32'h49);
    hit_request = '0;
    tick();
    chk("t3_r0", 32'({evt_valid, evt_rule, evt_x, evt_y}), 32'({1'b1, 3'd0, 11'd20, 11'd30}));
    tick();
    chk("t3_r3", 32'({evt_valid, evt_rule, evt_x, evt_y}), 32'({1'b1, 3'd3, 11'd20, 11'd30}));
    tick();
    chk("t3_r6", 32'({evt_valid, evt_rule, evt_x, evt_y}), 32'({1'b1, 3'd6, 11'd20, 11'd30}));
    tick();
    chk("t3_empty", 32'(evt_valid), 32'd0);

    // Six rules with the consumer stalled; two events lost at the frame boundary.
    evt_ready = 0; startOfFrame = 1; tick(); startOfFrame = 0;
    hit_request = 9'h1BF; pixelX = 7; pixelY = 9;
    tick();
    hit_request = '0;
    repeat (8) tick();
    startOfFrame = 1; tick(); startOfFrame = 0;
    chk("t4_drop", 32'(drop_count), 32'd2);
    chk("t4_summary", 32'(frame_summary), 32'h3F);
    chk("t4_head", 32'(evt_rule), 32'd0);

    // Full FIFO, rule 6 pending, one accepted pop lets it in the same cycle.
    hit_request = 9'h0C0; pixelX = 300; pixelY = 400;
    tick();
    hit_request = '0;
    tick(); tick();
    evt_ready = 1; tick(); evt_ready = 0;
    chk("t6_drop", 32'(drop_count), 32'd2);
    chk("t6_head", 32'(evt_rule), 32'd1);
    evt_ready = 1; cnt = 0; last_rule = -1;
    for (int i = 0; i < 10 && evt_valid; i++) begin
      last_rule = int'(evt_rule); cnt++;
      tick();
    end
    evt_ready = 0;
    chk("t6_occupancy", 32'(cnt), 32'd4);
    chk("t6_last_rule", 32'(last_rule), 32'd6);

    // Frame boundary coinciding with a rule 2 hit.
    startOfFrame = 1; hit_request = 9'h084; pixelX = 5; pixelY = 6;
    tick(); startOfFrame = 0;
    chk("t5_pulse", 32'(HitPulse), 32'h04);
    chk("t5_summary", 32'(frame_summary), 32'h40);
    hit_request = '0; tick();
    hit_request = 9'h084; pixelX = 8; tick();
    chk("t5_no_repulse", 32'(HitPulse), 32'd0);
    hit_request = '0; evt_ready = 1; repeat (3) tick(); evt_ready = 0;

    // Table-driven collision patterns.
    startOfFrame = 1; tick(); startOfFrame = 0;
    evt_ready = 1;
    foreach (tbl[i]) begin
      hit_request = tbl[i].hit; pixelX = CW'(i * 3); pixelY = CW'(i * 5);
      #1 chk("tbl_col", 32'(collision), 32'(tbl[i].col));
      tick();
    end
    hit_request = '0; repeat (8) tick();

    // Drop counter saturation with the consumer stalled.
    evt_ready = 0;
    for (int f = 0; f < 45; f++) begin
      hit_request = 9'h1FF; tick();
      hit_request = '0; tick();
      startOfFrame = 1; tick(); startOfFrame = 0;
    end
    chk("sat_drop", 32'(drop_count), 32'd255);

    // Reset while the FIFO is full and events are pending.
    hit_request = 9'h1FF; tick();
    resetN = 0; hit_request = '0; tick(); resetN = 1;
    chk("midrst_valid", 32'(evt_valid), 32'd0);
    chk("midrst_drop", 32'(drop_count), 32'd0);
    chk("midrst_summary", 32'(frame_summary), 32'd0);

    // Randomized run against the model.
    for (int c = 0; c < 3000; c++) begin
      hit_request  = NO'($urandom) & NO'($urandom);
      pixelX       = CW'($urandom);
      pixelY       = CW'($urandom);
      startOfFrame = ($urandom_range(0, 24) == 0);
      evt_ready    = ($urandom_range(0, 3) != 0);
      resetN       = ($urandom_range(0, 399) != 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
